ofdm_symbol_framer: RTL and testbench
=====================================

// Module: ofdm_symbol_framer
// PURPOSE
//  Transmit-side framer for the OFDM symbol sync block. Buffers one
//  OFDM_SYMBOL_LENGTH-sample packet from the IFFT on an Avalon-ST sink.
//  Emits a framed burst on an Avalon-ST source: a constant-amplitude preamble
//  step (trips the sync block's MA4/MA32 difference detector), the optional
//  cyclic prefix, then the symbol body. A silent guard follows the burst.
// PARAMETERS
//  OFDM_SYMBOL_LENGTH  64   samples per symbol; buffer depth
//  PREAMBLE_LEN        8    preamble beats
//  PREAMBLE_AMPLITUDE  1024 signed 16b value driven on both I and Q in preamble
//  CP_LEN              16   cyclic prefix beats; must satisfy 1..OFDM_SYMBOL_LENGTH
//  GUARD_LEN           520  idle cycles after burst; exceeds the 512-cycle sync slack
// PORTS
//  clock_clk               in   1   single clock
//  reset_reset             in   1   synchronous, active-high reset
//  asi_in0_data            in   32  [31:16] real, [15:0] imag, signed
//  asi_in0_valid           in   1   sink valid
//  asi_in0_startofpacket   in   1   sink first sample of symbol
//  asi_in0_endofpacket     in   1   sink last sample of symbol
//  asi_in0_ready           out  1   sink ready (ready latency 0)
//  aso_out0_data           out  32  framed sample, same packing
//  aso_out0_valid          out  1   source valid
//  aso_out0_ready          in   1   source ready (ready latency 0)
//  aso_out0_startofpacket  out  1   first preamble beat
//  aso_out0_endofpacket    out  1   last body beat
//  tx_active               out  1   high from first preamble beat to last body beat
//  frame_error             out  1   one-cycle pulse on a malformed input packet
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-burst aborts the
//   burst without eop. No partial symbol survives reset.
//  FSM: IDLE -> LOAD -> PREAMBLE -> [CP] -> BODY -> GUARD -> IDLE.
//  IDLE: ready=1. Beats without sop are dropped. A beat with sop is written to
//   buf[0], and the FSM enters LOAD with wr_idx=1.
//  LOAD: ready=1. Each accepted beat goes to buf[wr_idx], and wr_idx increments.
//   - Beat at wr_idx==N-1: load completes. frame_error pulses if eop=0.
//   - eop before N-1: buf[wr_idx+1..N-1] is zero-filled over the next cycles.
//     frame_error pulses. Load completes when the fill ends.
//   - sop inside LOAD: restart at buf[0], wr_idx=1, frame_error pulses.
//   - A packet that is a single beat with sop=eop=1 is a short packet.
//  PREAMBLE..GUARD: ready=0. Input is held off by backpressure; nothing is dropped.
//  Output: registered. Next cycle after load completes, valid=1 with preamble
//   beat 0 and sop=1. A beat transfers when valid&&ready. Data, valid, sop and
//   eop hold stable while ready=0. Beats are back-to-back while ready=1.
//  PREAMBLE: PREAMBLE_LEN beats of {PREAMBLE_AMPLITUDE, PREAMBLE_AMPLITUDE}.
//  CP: buf[N-CP_LEN .. N-1] in order.
//  BODY: buf[0 .. N-1]. eop=1 only on buf[N-1].
//  Sign: each buffered sample leaves as {-re,-im}, 16b two's complement
//   wrap, so -32768 stays -32768. The sync block's negation restores the value.
//   Preamble samples are not negated.
//  GUARD: valid=0 for exactly GUARD_LEN cycles after the eop transfer, then IDLE.
//   tx_active=0 during GUARD.
//  Counters are sized $clog2(max+1); the read index wraps only via explicit load.
// CONFIGURATION
//  OFDM_TX_CP_EN defined: the CP state is present and emits CP_LEN beats.
//   Burst length = PREAMBLE_LEN+CP_LEN+N.
//  Undefined: no CP state; PREAMBLE goes to BODY and CP_LEN is ignored.
//   Burst length = PREAMBLE_LEN+N.
// TESTING
//  T1 Sink packet 0x00010002..0x00400080 (sop/eop ok), ready=1 -> 8 beats
//     0x04000400 (sop on first), 16 CP beats of -buf[48..63], 64 body beats
//     0xFFFFFFFE.. (eop on last), then 520 idle cycles, frame_error never set.
//  T2 Toggle aso_out0_ready every other cycle during T1 -> identical beat
//     sequence; data, sop and eop are stable across every stalled cycle.
//  T3 Short packet of 10 beats, eop on beat 10 -> frame_error pulse;
//     body beats 10..63 = 0x00000000.
//  T4 sop re-asserted at beat 20 of a packet -> frame_error pulse; the
//     buffer restarts; the emitted body equals the second packet.
//  T5 Sample 0x80008000 -> body beat 0x80008000. Beats without sop while
//     IDLE are dropped and produce no output.
//  T6 reset_reset for 1 cycle during BODY -> next cycle all outputs 0, no eop.
//     A new packet is then framed normally. Re-run T1 with OFDM_TX_CP_EN
//     undefined -> 72-beat burst.

Source files
------------

// File: rtl/ofdm_symbol_framer.sv
// Transmit framer: buffers one OFDM symbol and emits preamble, optional cyclic prefix, negated body, then a silent guard.
// Optional cyclic prefix stage is built when OFDM_TX_CP_EN is defined.
module ofdm_symbol_framer #(
    parameter int OFDM_SYMBOL_LENGTH = 64,
    parameter int PREAMBLE_LEN       = 8,
    parameter int PREAMBLE_AMPLITUDE = 1024,
    parameter int CP_LEN             = 16,
    parameter int GUARD_LEN          = 520
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [31:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic        asi_in0_ready,
    output logic [31:0] aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    output logic        tx_active,
    output logic        frame_error
);

    localparam int N  = OFDM_SYMBOL_LENGTH;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(N + 1);
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam int GW = $clog2(GUARD_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PREAMBLE_LEN - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_LEN - 1);
    localparam logic [31:0]   PRE_WORD   = {16'(PREAMBLE_AMPLITUDE), 16'(PREAMBLE_AMPLITUDE)};
`ifdef OFDM_TX_CP_EN
    localparam logic [IW-1:0] CP_FIRST   = IW'(N - CP_LEN);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_FILL     = 3'd2,
        ST_PREAMBLE = 3'd3,
`ifdef OFDM_TX_CP_EN
        ST_CP       = 3'd4,
`endif
        ST_BODY     = 3'd5,
        ST_GUARD    = 3'd6
    } state_t;

    state_t         state_r;
    logic [31:0]    buf_r [N];
    logic [IW-1:0]  wr_idx_r;
    logic [IW-1:0]  rd_idx_r;
    logic [PW-1:0]  pre_cnt_r;
    logic [GW-1:0]  guard_cnt_r;
    logic           ready_r, valid_r, sop_r, eop_r, tx_active_r, frame_error_r;
    logic [31:0]    data_r;

    logic           acc_s, xfer_s, we_s, restart_s, fe_s, load_done_s;
    logic [IW-1:0]  pos_s, rd_nxt_s;
    logic [AW-1:0]  widx_s;
    logic [31:0]    wdata_s;

    // The sync block negates again, so samples leave with both halves wrapped-negated.
    function automatic logic [31:0] neg_sample(input logic [31:0] s);
        return {16'h0000 - s[31:16], 16'h0000 - s[15:0]};
    endfunction

    assign acc_s    = asi_in0_valid && ready_r;
    assign xfer_s   = valid_r && aso_out0_ready;
    assign rd_nxt_s = rd_idx_r + IDX_ONE;

    // Buffer write-port decode and malformed-packet detection.
    always_comb begin
        we_s        = 1'b0;
        widx_s      = {AW{1'b0}};
        wdata_s     = 32'h0000_0000;
        pos_s       = {IW{1'b0}};
        restart_s   = 1'b0;
        fe_s        = 1'b0;
        load_done_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (acc_s && (asi_in0_startofpacket || (state_r == ST_LOAD))) begin
                    we_s        = 1'b1;
                    restart_s   = (state_r == ST_LOAD) && asi_in0_startofpacket;
                    pos_s       = asi_in0_startofpacket ? {IW{1'b0}} : wr_idx_r;
                    widx_s      = pos_s[AW-1:0];
                    wdata_s     = asi_in0_data;
                    load_done_s = (pos_s == LAST_IDX);
                    fe_s        = restart_s || (load_done_s ? !asi_in0_endofpacket : asi_in0_endofpacket);
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_FILL: begin
                we_s        = 1'b1;
                widx_s      = wr_idx_r[AW-1:0];
                load_done_s = (wr_idx_r == LAST_IDX);
            end
            default: we_s = 1'b0;
        endcase
    end

    // Symbol buffer; every slot is rewritten (data or zero fill) before it is read.
    always_ff @(posedge clock_clk) begin
        if (we_s) begin
            buf_r[widx_s] <= wdata_s;
        end
    end

    // Framer state machine with registered sink-ready and source outputs.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_r       <= ST_IDLE;
            wr_idx_r      <= {IW{1'b0}};
            rd_idx_r      <= {IW{1'b0}};
            pre_cnt_r     <= {PW{1'b0}};
            guard_cnt_r   <= {GW{1'b0}};
            ready_r       <= 1'b0;
            valid_r       <= 1'b0;
            sop_r         <= 1'b0;
            eop_r         <= 1'b0;
            tx_active_r   <= 1'b0;
            frame_error_r <= 1'b0;
            data_r        <= 32'h0000_0000;
        end else begin
            frame_error_r <= fe_s;
            case (state_r)
                ST_IDLE, ST_LOAD, ST_FILL: begin
                    if (load_done_s) begin
                        state_r     <= ST_PREAMBLE;
                        ready_r     <= 1'b0;
                        valid_r     <= 1'b1;
                        data_r      <= PRE_WORD;
                        sop_r       <= 1'b1;
                        eop_r       <= 1'b0;
                        tx_active_r <= 1'b1;
                        pre_cnt_r   <= {PW{1'b0}};
                    end else if (state_r == ST_FILL) begin
                        wr_idx_r <= wr_idx_r + IDX_ONE;
                    end else if (we_s) begin
                        wr_idx_r <= pos_s + IDX_ONE;
                        // Early eop: sink is held off while the tail is zero-filled.
                        state_r  <= asi_in0_endofpacket ? ST_FILL : ST_LOAD;
                        ready_r  <= !asi_in0_endofpacket;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (xfer_s) begin
                        sop_r <= 1'b0;
                        if (pre_cnt_r == PRE_LAST) begin
`ifdef OFDM_TX_CP_EN
                            state_r  <= ST_CP;
                            rd_idx_r <= CP_FIRST;
                            data_r   <= neg_sample(buf_r[CP_FIRST[AW-1:0]]);
                            eop_r    <= 1'b0;
`else
                            state_r  <= ST_BODY;
                            rd_idx_r <= {IW{1'b0}};
                            data_r   <= neg_sample(buf_r[0]);
                            eop_r    <= (N == 1);
`endif
                        end else begin
                            pre_cnt_r <= pre_cnt_r + PW'(1);
                        end
                    end
                end
`ifdef OFDM_TX_CP_EN
                ST_CP: begin
                    if (xfer_s) begin
                        if (rd_idx_r == LAST_IDX) begin
                            state_r  <= ST_BODY;
                            rd_idx_r <= {IW{1'b0}};
                            data_r   <= neg_sample(buf_r[0]);
                            eop_r    <= (N == 1);
                        end else begin
                            rd_idx_r <= rd_nxt_s;
                            data_r   <= neg_sample(buf_r[rd_nxt_s[AW-1:0]]);
                        end
                    end
                end
`endif
                ST_BODY: begin
                    if (xfer_s) begin
                        if (rd_idx_r == LAST_IDX) begin
                            state_r     <= ST_GUARD;
                            valid_r     <= 1'b0;
                            eop_r       <= 1'b0;
                            data_r      <= 32'h0000_0000;
                            tx_active_r <= 1'b0;
                            guard_cnt_r <= {GW{1'b0}};
                        end else begin
                            rd_idx_r <= rd_nxt_s;
                            data_r   <= neg_sample(buf_r[rd_nxt_s[AW-1:0]]);
                            eop_r    <= (rd_nxt_s == LAST_IDX);
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + GW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign asi_in0_ready          = ready_r;
    assign aso_out0_data          = data_r;
    assign aso_out0_valid         = valid_r;
    assign aso_out0_startofpacket = sop_r;
    assign aso_out0_endofpacket   = eop_r;
    assign tx_active              = tx_active_r;
    assign frame_error            = frame_error_r;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Scoreboard bench for ofdm_symbol_framer: expected bursts are queued as packets are driven and popped on each source transfer.
module tb_ofdm_symbol_framer;

    localparam int N     = 64;
    localparam int PRE   = 8;
    localparam int GUARD = 520;
`ifdef OFDM_TX_CP_EN
    localparam int CPB   = 16;
`else
    localparam int CPB   = 0;
`endif
    localparam logic [31:0] PRE_WORD = 32'h0400_0400;

    logic        clock_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] asi_in0_data = 32'h0;
    logic        asi_in0_valid = 1'b0;
    logic        asi_in0_startofpacket = 1'b0;
    logic        asi_in0_endofpacket = 1'b0;
    logic        asi_in0_ready;
    logic [31:0] aso_out0_data;
    logic        aso_out0_valid;
    logic        aso_out0_ready = 1'b1;
    logic        aso_out0_startofpacket;
    logic        aso_out0_endofpacket;
    logic        tx_active;
    logic        frame_error;

    ofdm_symbol_framer dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (asi_in0_valid),
        .asi_in0_startofpacket  (asi_in0_startofpacket),
        .asi_in0_endofpacket    (asi_in0_endofpacket),
        .asi_in0_ready          (asi_in0_ready),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .tx_active              (tx_active),
        .frame_error            (frame_error)
    );

    initial begin
        forever #5 clock_clk = ~clock_clk;
    end

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pkt  [N];
    logic [31:0] msym [N];
    int          total = 0;
    int          bad = 0;
    int          err_cnt = 0;
    int          pop_cnt = 0;
    bit          toggle_en = 1'b0;
    bit          guard_run = 1'b0;
    int          gcnt = 0;
    int          gvalid = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] neg_word(input logic [31:0] w);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'h0000 - w[31:16];
        im = 16'h0000 - w[15:0];
        return {re, im};
    endfunction

    task automatic push_burst();
        for (int i = 0; i < PRE; i++) exp_q.push_back('{PRE_WORD, (i == 0), 1'b0});
        for (int i = N - CPB; i < N; i++) exp_q.push_back('{neg_word(msym[i]), 1'b0, 1'b0});
        for (int i = 0; i < N; i++) exp_q.push_back('{neg_word(msym[i]), 1'b0, (i == N - 1)});
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
        bit acc;
        int budget;
        asi_in0_data = d;
        asi_in0_startofpacket = sop;
        asi_in0_endofpacket = eop;
        asi_in0_valid = 1'b1;
        acc = 1'b0;
        budget = 3000;
        while (!acc && budget > 0) begin
            @(negedge clock_clk);
            acc = asi_in0_ready;
            @(posedge clock_clk);
            #1;
            budget--;
        end
        if (!acc) check_val("sink_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_in();
        asi_in0_valid = 1'b0;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket = 1'b0;
    endtask

    task automatic send_packet(input int count);
        for (int i = 0; i < count; i++) send_beat(pkt[i], (i == 0), (i == count - 1));
        idle_in();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || guard_run) && n < 3000) begin
            @(negedge clock_clk);
            n++;
        end
        check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_guard_open"}, 32'(guard_run), 32'd0);
        @(posedge clock_clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clock_clk);
            #1;
            aso_out0_ready = toggle_en ? ~aso_out0_ready : 1'b1;
        end
    end

    // Source monitor: scoreboard pop, hold-while-stalled, guard length, error pulses.
    initial begin
        bit    stall_prev;
        beat_t held;
        beat_t e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clock_clk);
            if (reset_reset) begin
                stall_prev = 1'b0;
                guard_run = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_val("hold_valid", 32'(aso_out0_valid), 32'd1);
                    check_val("hold_data", aso_out0_data, held.d);
                    check_val("hold_sop", 32'(aso_out0_startofpacket), 32'(held.sop));
                    check_val("hold_eop", 32'(aso_out0_endofpacket), 32'(held.eop));
                end
                if (guard_run) begin
                    if (asi_in0_ready) begin
                        check_val("guard_len", 32'(gcnt), 32'(GUARD));
                        check_val("guard_valid", 32'(gvalid), 32'd0);
                        guard_run = 1'b0;
                    end else begin
                        gcnt++;
                        if (aso_out0_valid) gvalid++;
                    end
                end
                if (frame_error) err_cnt++;
                if (aso_out0_valid && aso_out0_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_beat", aso_out0_data, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("beat_data", aso_out0_data, e.d);
                        check_val("beat_sop", 32'(aso_out0_startofpacket), 32'(e.sop));
                        check_val("beat_eop", 32'(aso_out0_endofpacket), 32'(e.eop));
                        check_val("tx_active", 32'(tx_active), 32'd1);
                        pop_cnt++;
                        if (aso_out0_endofpacket) begin
                            guard_run = 1'b1;
                            gcnt = 0;
                            gvalid = 0;
                        end
                    end
                end
                stall_prev = aso_out0_valid && !aso_out0_ready;
                held = '{aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket};
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 32'(aso_out0_valid), 32'd0);
        check_val({tag, "_sop"}, 32'(aso_out0_startofpacket), 32'd0);
        check_val({tag, "_eop"}, 32'(aso_out0_endofpacket), 32'd0);
        check_val({tag, "_data"}, aso_out0_data, 32'd0);
        check_val({tag, "_txa"}, 32'(tx_active), 32'd0);
        check_val({tag, "_ferr"}, 32'(frame_error), 32'd0);
        check_val({tag, "_ready"}, 32'(asi_in0_ready), 32'd0);
    endtask

    task automatic fill_pattern(input int seed);
        for (int i = 0; i < N; i++) begin
            pkt[i]  = {16'(i * seed + 3), 16'(i * 7 + seed)};
            msym[i] = pkt[i];
        end
    endtask

    initial begin
        int e0;
        int p0;
        int n;
        repeat (3) @(posedge clock_clk);
        @(negedge clock_clk);
        check_all_zero("reset");
        @(posedge clock_clk);
        #1;
        reset_reset = 1'b0;

        // T1: canonical packet, ready held high
        for (int i = 0; i < N; i++) begin
            pkt[i]  = {16'(i + 1), 16'(2 * i + 2)};
            msym[i] = pkt[i];
        end
        e0 = err_cnt;
        push_burst();
        send_packet(N);
        wait_done("t1");
        check_val("t1_ferr", 32'(err_cnt - e0), 32'd0);

        // T2: same packet with the source stalling every other cycle
        toggle_en = 1'b1;
        push_burst();
        send_packet(N);
        wait_done("t2");
        toggle_en = 1'b0;
        @(posedge clock_clk);
        #1;

        // T3: short packet of 10 beats, tail zero-filled
        fill_pattern(5);
        for (int i = 10; i < N; i++) msym[i] = 32'h0;
        e0 = err_cnt;
        push_burst();
        send_packet(10);
        wait_done("t3");
        check_val("t3_ferr", 32'(err_cnt - e0), 32'd1);

        // T4: sop re-asserted at beat 20; second packet wins
        e0 = err_cnt;
        fill_pattern(11);
        for (int i = 0; i < 19; i++) send_beat(pkt[i], (i == 0), 1'b0);
        fill_pattern(13);
        push_burst();
        send_packet(N);
        wait_done("t4");
        check_val("t4_ferr", 32'(err_cnt - e0), 32'd1);

        // T5: beats without sop are dropped; full-scale negative stays put
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) send_beat(32'h1234_5678 + 32'(i), 1'b0, 1'b0);
        idle_in();
        repeat (5) @(posedge clock_clk);
        @(negedge clock_clk);
        check_val("t5_drop_valid", 32'(aso_out0_valid), 32'd0);
        check_val("t5_drop_ready", 32'(asi_in0_ready), 32'd1);
        @(posedge clock_clk);
        #1;
        fill_pattern(17);
        pkt[0]  = 32'h8000_8000;
        msym[0] = pkt[0];
        pkt[1]  = 32'h7FFF_8001;
        msym[1] = pkt[1];
        check_val("t5_neg_model", neg_word(msym[0]), 32'h8000_8000);
        push_burst();
        send_packet(N);
        wait_done("t5");
        check_val("t5_ferr", 32'(err_cnt - e0), 32'd0);

        // T6: reset during BODY aborts the burst, then a normal burst follows
        fill_pattern(19);
        p0 = pop_cnt;
        push_burst();
        send_packet(N);
        n = 0;
        while (pop_cnt < p0 + PRE + CPB + 10 && n < 3000) begin
            @(negedge clock_clk);
            n++;
        end
        check_val("t6_reach_body", 32'(pop_cnt >= p0 + PRE + CPB + 10), 32'd1);
        @(posedge clock_clk);
        #1;
        reset_reset = 1'b1;
        @(posedge clock_clk);
        #1;
        reset_reset = 1'b0;
        @(negedge clock_clk);
        check_all_zero("t6_abort");
        exp_q.delete();
        @(posedge clock_clk);
        #1;
        fill_pattern(23);
        e0 = err_cnt;
        push_burst();
        send_packet(N);
        wait_done("t6");
        check_val("t6_ferr", 32'(err_cnt - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
